// File: rtl/race_pkg.sv
// Shared types and defaults for the racing game controller.
package race_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } race_state_e;

  localparam int unsigned WIN_DIST_DEF  = 65;
  localparam int unsigned LOSE_DIST_DEF = 32'h7FFF;

  function automatic int unsigned scale_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/race_state_ctrl_fade_scaler.sv
// Frame divider plus saturating fade scale driven by collisions on each fade step.
module fade_scaler
  import race_pkg::*;
#(
  parameter int unsigned FADE_DIV     = 16,
  parameter int unsigned SCALE_W      = 3,
  parameter int unsigned RECOVER_MODE = 0
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               any_coll,
  output logic [SCALE_W-1:0] scale,
  output logic               fade_tick
);

  localparam int unsigned        DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FADE_DIV - 1);
  localparam logic [SCALE_W-1:0] SMAX     = SCALE_W'(scale_max(SCALE_W));

  logic [DIV_W-1:0] div_cnt;
  logic             tick_now;

  assign tick_now = enable && (div_cnt == DIV_LAST);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      div_cnt   <= '0;
      scale     <= '0;
      fade_tick <= 1'b0;
    end else if (clear) begin
      div_cnt   <= '0;
      scale     <= '0;
      fade_tick <= 1'b0;
    end else begin
      fade_tick <= tick_now;
      if (enable)
        div_cnt <= tick_now ? '0 : div_cnt + 1'b1;
      // collision level only matters on the step cycle itself
      if (tick_now) begin
        if (any_coll) begin
          if (scale != SMAX) scale <= scale + 1'b1;
        end else if (RECOVER_MODE != 0) begin
          if (scale != '0) scale <= scale - 1'b1;
        end else begin
          scale <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/race_state_ctrl.sv
// Game FSM, distance accumulator and edge-qualified start for the racing pipeline.
module race_state_ctrl
  import race_pkg::*;
#(
  parameter int unsigned DIST_W       = 16,
  parameter int unsigned SCALE_W      = 3,
  parameter int unsigned FADE_DIV     = 16,
  parameter int unsigned NUM_COLL     = 4,
  parameter int unsigned WIN_DIST     = WIN_DIST_DEF,
  parameter int unsigned LOSE_DIST    = LOSE_DIST_DEF,
  parameter int unsigned RECOVER_MODE = 0
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [7:0]          start_key,
  input  logic [NUM_COLL-1:0] collide,
  input  logic [DIST_W-1:0]   tar_distance,
  input  logic [9:0]          ground_speed,
  output logic [DIST_W-1:0]   distance,
  output logic [SCALE_W-1:0]  scale,
  output logic [1:0]          state,
  output logic                game_start,
  output logic                game_win,
  output logic                game_lose,
  output logic                fade_tick
);

  localparam logic [SCALE_W-1:0] SMAX = SCALE_W'(scale_max(SCALE_W));

  race_state_e cur_st, nxt_st;
  logic        prev_nz, start_req, run_en, any_coll, lose_cond, win_cond;

  assign start_req = (start_key != '0) && !prev_nz;
  assign any_coll  = |collide;
  // thresholds compared at 32 bits so narrow DIST_W never truncates them
  assign lose_cond = (32'(tar_distance) >= LOSE_DIST) || (scale == SMAX);
  assign win_cond  = 32'(tar_distance) <= WIN_DIST;
  assign run_en    = (cur_st == RUN) && !start_req;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cur_st     <= IDLE;
      prev_nz    <= 1'b0;
      game_start <= 1'b0;
    end else begin
      cur_st  <= nxt_st;
      prev_nz <= (start_key != '0);
      if (start_req) game_start <= 1'b1;
    end
  end

  always_comb begin
    nxt_st = cur_st;
    if (start_req)
      nxt_st = RUN;
    else if (cur_st == RUN) begin
      if (lose_cond)     nxt_st = LOSE;
      else if (win_cond) nxt_st = WIN;
    end
  end

  always_comb begin
    state     = cur_st;
    game_win  = (cur_st == WIN);
    game_lose = (cur_st == LOSE);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      distance <= '0;
    else if (start_req)
      distance <= '0;
    else if (cur_st == RUN)
      distance <= distance + DIST_W'(ground_speed);
  end

  fade_scaler #(
    .FADE_DIV    (FADE_DIV),
    .SCALE_W     (SCALE_W),
    .RECOVER_MODE(RECOVER_MODE)
  ) u_fade (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .enable   (run_en),
    .clear    (start_req),
    .any_coll (any_coll),
    .scale    (scale),
    .fade_tick(fade_tick)
  );

endmodule
